// File: rtl/bus_arb_pkg.sv
// Shared types and sizing helpers for the round-robin bus arbiter.
//   arb_state_e : arbiter FSM state encoding
//   idx_w()     : width of a master index (at least one bit)
//   lock_cnt_w(): width of the lock-hold counter for a given LOCK_MAX
package bus_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_GRANT  = 2'd1,
    ST_LOCKED = 2'd2
  } arb_state_e;

  // Index width for n masters; never collapses to zero bits.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // The counter only has to reach lock_max-1; unlimited locks (0) still get one bit.
  function automatic int unsigned lock_cnt_w(input int unsigned lock_max);
    return (lock_max > 2) ? $clog2(lock_max) : 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Rotate-and-find-first: returns the first set bit of req scanning upward
// from ptr and wrapping from N-1 to 0.
//   req : per-master candidate vector
//   ptr : scan start position (must be < N)
//   idx : index of the selected master (0 when none)
//   vld : high when any bit of req is set
module rr_pick
  import bus_arb_pkg::*;
#(
  parameter int unsigned N  = 4,
  parameter int unsigned IW = idx_w(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [IW-1:0] idx,
  output logic          vld
);

  localparam int unsigned SW = IW + 1;

  logic [SW-1:0] pos;

  // Walk offsets from farthest to nearest so the nearest requester wins last.
  always_comb begin
    idx = '0;
    vld = 1'b0;
    pos = '0;
    for (int i = int'(N) - 1; i >= 0; i--) begin
      pos = SW'({1'b0, ptr}) + SW'(i);
      if (pos >= SW'(N)) begin
        pos = pos - SW'(N);
      end
      if (req[pos[IW-1:0]]) begin
        idx = pos[IW-1:0];
        vld = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bus_arbiter_rr.sv
// Round-robin bus arbiter with bounded bus locking.
//   clk, rst            : clock, asynchronous active-high reset
//   bus_req, bus_lock   : per-master request and lock (lock only counts with req)
//   bus_grant           : registered one-hot (or zero) grant
//   grant_idx, grant_vld: registered owner index and grant-active flag
//   addr_m, wd_m, we_m  : per-master address, write data, write enable
//   addr_f, wd_f, we_f  : owner's address/data/enable, zero when idle
module bus_arbiter_rr
  import bus_arb_pkg::*;
#(
  parameter int unsigned M_W      = 4,
  parameter int unsigned AW       = 32,
  parameter int unsigned DW       = 32,
  parameter int unsigned LOCK_MAX = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [M_W-1:0]              bus_req,
  input  logic [M_W-1:0]              bus_lock,
  output logic [M_W-1:0]              bus_grant,
  output logic [$clog2(M_W)-1:0]      grant_idx,
  output logic                        grant_vld,
  input  logic [M_W-1:0][AW-1:0]      addr_m,
  input  logic [M_W-1:0][DW-1:0]      wd_m,
  input  logic [M_W-1:0]              we_m,
  output logic [AW-1:0]               addr_f,
  output logic [DW-1:0]               wd_f,
  output logic                        we_f
);

  localparam int unsigned IW = idx_w(M_W);
  localparam int unsigned CW = lock_cnt_w(LOCK_MAX);
  localparam int unsigned PW = IW + 1;

  arb_state_e     state_q, state_d;
  logic [IW-1:0]  ptr_q, ptr_d;
  logic [CW-1:0]  lock_cnt_q, lock_cnt_d;
  logic [M_W-1:0] grant_q, grant_d;
  logic [IW-1:0]  idx_q, idx_d;
  logic           vld_q, vld_d;

  logic           force_rel;
  logic           owner_hold;
  logic [M_W-1:0] pick_req;
  logic [IW-1:0]  pick_idx;
  logic           pick_vld;
  logic [PW-1:0]  ptr_nxt;
  logic           do_arb;

  // A lock that has used up its budget must give way for one arbitration.
  assign force_rel  = (state_q == ST_LOCKED) && (LOCK_MAX != 0) &&
                      (lock_cnt_q == CW'(LOCK_MAX - 1));
  assign owner_hold = bus_req[idx_q] && bus_lock[idx_q] && !force_rel;
  assign pick_req   = bus_req & ~(force_rel ? grant_q : '0);

  rr_pick #(
    .N  (M_W),
    .IW (IW)
  ) u_pick (
    .req (pick_req),
    .ptr (ptr_q),
    .idx (pick_idx),
    .vld (pick_vld)
  );

  // Pointer moves just past the winner, wrapping at M_W.
  always_comb begin
    ptr_nxt = PW'(pick_idx) + PW'(1);
    if (ptr_nxt >= PW'(M_W)) begin
      ptr_nxt = '0;
    end
  end

  // Next-state and next-grant logic.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    lock_cnt_d = lock_cnt_q;
    grant_d    = grant_q;
    idx_d      = idx_q;
    vld_d      = vld_q;
    do_arb     = 1'b0;

    unique case (state_q)
      ST_IDLE:  do_arb = 1'b1;
      ST_GRANT: do_arb = 1'b1;
      ST_LOCKED: begin
        if (owner_hold) begin
          lock_cnt_d = lock_cnt_q + CW'(1);
        end else begin
          do_arb = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        grant_d = '0;
        idx_d   = '0;
        vld_d   = 1'b0;
      end
    endcase

    if (do_arb) begin
      if (pick_vld) begin
        grant_d = M_W'(1) << pick_idx;
        idx_d   = pick_idx;
        vld_d   = 1'b1;
        ptr_d   = ptr_nxt[IW-1:0];
        if (bus_lock[pick_idx]) begin
          state_d    = ST_LOCKED;
          lock_cnt_d = '0;
        end else begin
          state_d = ST_GRANT;
        end
      end else begin
        // Nobody eligible (including a forced-out lone owner): idle one cycle.
        state_d = ST_IDLE;
        grant_d = '0;
        idx_d   = '0;
        vld_d   = 1'b0;
      end
    end
  end

  // State and grant registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      ptr_q      <= '0;
      lock_cnt_q <= '0;
      grant_q    <= '0;
      idx_q      <= '0;
      vld_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      lock_cnt_q <= lock_cnt_d;
      grant_q    <= grant_d;
      idx_q      <= idx_d;
      vld_q      <= vld_d;
    end
  end

  assign bus_grant = grant_q;
  assign grant_idx = idx_q;
  assign grant_vld = vld_q;

  // Forwarding mux follows the registered owner; forced to zero when idle.
  assign addr_f = vld_q ? addr_m[idx_q] : '0;
  assign wd_f   = vld_q ? wd_m[idx_q]   : '0;
  assign we_f   = vld_q ? we_m[idx_q]   : 1'b0;

endmodule

// File: doc/bus_arbiter_rr.md
BUS_ARBITER_RR -- requirements
Module: bus_arbiter_rr

Interface
REQ-001 Parameter M_W, default 4, SHALL set the number of masters (2..16).
REQ-002 Parameter AW, default 32, SHALL set the address width.
REQ-003 Parameter DW, default 32, SHALL set the write-data width.
REQ-004 Parameter LOCK_MAX, default 16, SHALL set the maximum number of cycles a locked grant is held (0 = unlimited).
REQ-005 clk  in  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-006 rst  in  1  SHALL be the reset: asynchronous, active-high.
REQ-007 bus_req  in  M_W  SHALL carry per-master bus requests.
REQ-008 bus_lock  in  M_W  SHALL carry per-master lock requests, valid only together with bus_req.
REQ-009 bus_grant  out  M_W  SHALL be the registered grant, one-hot or zero.
REQ-010 grant_idx  out  $clog2(M_W)  SHALL carry the index of the current owner (0 when idle).
REQ-011 grant_vld  out  1  SHALL be high when any grant is active.
REQ-012 addr_m, wd_m, we_m  in  M_W x AW, M_W x DW, M_W x 1  SHALL carry per-master address, write data and write enable.
REQ-013 addr_f, wd_f, we_f  out  AW, DW, 1  SHALL carry the forwarded address, write data and write enable.

Function
REQ-014 FSM states SHALL be IDLE, GRANT and LOCKED.
REQ-015 IDLE: with bus_req == 0, stay in IDLE; otherwise grant the winner in the next cycle and enter GRANT, or enter LOCKED if the winner's bus_lock is high.
REQ-016 The winner SHALL be the first requester scanning upward from ptr, wrapping from M_W-1 to 0.
REQ-017 ptr SHALL be set to (winner+1) mod M_W on every new grant.
REQ-018 GRANT: each cycle, re-arbitrate among all requesters; the owner SHALL compete at its round-robin position; no requests SHALL return the FSM to IDLE with the grant cleared.
REQ-019 LOCKED: the grant SHALL be held while the owner's bus_req && bus_lock are high; on deassertion, arbitrate per REQ-018.
REQ-020 Lock counter SHALL clear on entry to LOCKED and increment each LOCKED cycle.
REQ-021 If LOCK_MAX != 0 and the counter reaches LOCK_MAX-1, the next arbitration SHALL exclude the owner.
REQ-022 If only the owner is requesting at a forced release, the grant SHALL drop to zero for one cycle and then re-grant the owner.
REQ-023 Grant latency SHALL be one cycle from request to bus_grant.
REQ-024 A grant SHALL change only on a clock edge, and at most one bit SHALL ever be high.
REQ-025 The outputs addr_f, wd_f and we_f SHALL be a combinational mux on grant_idx.
REQ-026 When grant_vld is low, addr_f, wd_f and we_f SHALL be zero.
REQ-027 Simultaneous requests SHALL be resolved by ptr alone; bus_lock SHALL not affect priority.
REQ-028 bus_lock without bus_req SHALL be ignored.

Reset
REQ-029 While rst is high, the FSM SHALL be in IDLE, ptr = 0, lock counter = 0, bus_grant = 0, grant_idx = 0 and grant_vld = 0.
REQ-030 Reset asserted mid-grant or mid-lock SHALL clear all state immediately; the outputs addr_f, wd_f and we_f SHALL be zero in the same cycle.
REQ-031 The first arbitration after rst deasserts SHALL start from ptr = 0.

Structure
REQ-032 The FSM state enum and the lock-counter width function SHALL live in package bus_arb_pkg.
REQ-033 Rotate-and-find-first SHALL be a combinational sub-module rr_pick (inputs: req, ptr; outputs: idx, vld).
REQ-034 The top level SHALL contain the FSM, ptr, lock counter, grant register and output mux only.

Verification
REQ-035 M_W=4: bus_req=4'b1111 held for 8 cycles -> grant_idx sequence 0,1,2,3,0,1,2,3.
REQ-036 Master 2 requests with lock while master 0 requests, LOCK_MAX=4 -> master 2 held for exactly 4 cycles, then master 0 granted.
REQ-037 bus_req=4'b0100 with bus_lock high, LOCK_MAX=4, no other requester -> 4 cycles granted, 1 cycle bus_grant=0, then re-granted.
REQ-038 Master 3 owner with addr_m[3]=32'hDEAD_BEEF and we_m[3]=1 -> addr_f=32'hDEAD_BEEF, we_f=1; idle -> all zero.
REQ-039 rst pulsed while LOCKED on master 1 -> bus_grant=0 immediately; after release, bus_req=4'b0011 -> master 0 granted first.
REQ-040 Random requests and locks for 10k cycles -> bus_grant is always one-hot or zero, and no requester waits more than (M_W-1)*LOCK_MAX+M_W cycles.
